// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with a mandatory
// all-off dead time after every drive period so bufif drivers never overlap.
module tristate_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DEAD_CYC = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           drive_en,
    output logic [$clog2(N_REQ)-1:0]   sel,
    output logic                       busy
);
    localparam int SEL_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [DEAD_W-1:0]  dead_cnt_reg, dead_cnt_next;
    logic [N_REQ-1:0]   drive_en_reg, drive_en_next;
    logic               busy_reg, busy_next;

    logic [N_REQ-1:0]   sel_onehot;
    logic [N_REQ-1:0]   sel_next_onehot;
    logic               owner_req;
    logic               other_req;
    logic               hold_last;
    logic               dead_last;
    logic               hi_found;
    logic [SEL_W-1:0]   hi_idx;
    logic [SEL_W-1:0]   lo_idx;
    logic [SEL_W-1:0]   win_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
        assign sel_onehot[gi]      = (sel_reg  == SEL_W'(gi));
        assign sel_next_onehot[gi] = (sel_next == SEL_W'(gi));
    end

    assign owner_req = |(req & sel_onehot);
    assign other_req = |(req & ~sel_onehot);
    assign hold_last = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
    assign dead_last = (dead_cnt_reg == DEAD_W'(DEAD_CYC - 1));

    // Round-robin: lowest set bit above ptr, otherwise lowest set bit overall.
    // The previous owner sits last in this order, so it is re-granted only
    // when nobody else is asking.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (SEL_W'(i) > ptr_reg)) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(i);
            end
            if (req[i]) begin
                lo_idx = SEL_W'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        dead_cnt_next = dead_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = DRIVE;
                    sel_next      = win_idx;
                    ptr_next      = win_idx;
                    hold_cnt_next = '0;
                end
            end
            DRIVE: begin
                if (!owner_req || (hold_last && other_req)) begin
                    state_next    = TURN;
                    dead_cnt_next = '0;
                end else if (!hold_last) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            TURN: begin
                if (dead_last) begin
                    if (|req) begin
                        state_next    = DRIVE;
                        sel_next      = win_idx;
                        ptr_next      = win_idx;
                        hold_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    dead_cnt_next = dead_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        drive_en_next = (state_next == DRIVE) ? sel_next_onehot : '0;
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            ptr_reg      <= SEL_W'(N_REQ - 1);
            hold_cnt_reg <= '0;
            dead_cnt_reg <= '0;
            drive_en_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            dead_cnt_reg <= dead_cnt_next;
            drive_en_reg <= drive_en_next;
            busy_reg     <= busy_next;
        end
    end

    assign drive_en = drive_en_reg;
    assign sel      = sel_reg;
    assign busy     = busy_reg;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed cycle-exact scenarios against a queue of expected outputs, then a
// randomized run watching exclusivity, dead time and grant latency.
module tb_tristate_bus_arbiter;
    localparam int N     = 2;
    localparam int DEAD  = 2;
    localparam int HOLD  = 4;
    localparam int BOUND = (N - 1) * (HOLD + DEAD) + DEAD + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] drive_en;
    logic [0:0]   sel;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [3:0] exp_q[$];

    tristate_bus_arbiter #(.N_REQ(N), .DEAD_CYC(DEAD), .MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .drive_en(drive_en), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mk(input logic [1:0] de, input logic s, input logic b);
        return {de, s, b};
    endfunction

    // Leaves the bench just after the last reset edge; the next edge is cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e, got;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req = 2'b00;
            exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            @(negedge clk);
            got = {drive_en, sel, busy};
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("FAIL reset cyc%0d: got %b expected %b", k, got, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_grant();
        logic [3:0] e, got;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            req = (k < 5) ? 2'b01 : 2'b00;
            if (k == 0)      exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            else if (k <= 5) exp_q.push_back(mk(2'b01, 1'b0, 1'b1));
            else if (k <= 7) exp_q.push_back(mk(2'b00, 1'b0, 1'b1));
            else             exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            @(negedge clk);
            got = {drive_en, sel, busy};
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("FAIL single_grant cyc%0d: got %b expected %b", k, got, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] e, got;
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk); #1;
            req = 2'b11;
            if (k == 0)       exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            else if (k <= 4)  exp_q.push_back(mk(2'b01, 1'b0, 1'b1));
            else if (k <= 6)  exp_q.push_back(mk(2'b00, 1'b0, 1'b1));
            else if (k <= 10) exp_q.push_back(mk(2'b10, 1'b1, 1'b1));
            else if (k <= 12) exp_q.push_back(mk(2'b00, 1'b1, 1'b1));
            else              exp_q.push_back(mk(2'b01, 1'b0, 1'b1));
            @(negedge clk);
            got = {drive_en, sel, busy};
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("FAIL round_robin cyc%0d: got %b expected %b", k, got, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_no_competitor();
        logic [3:0] e, got;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            req = 2'b01;
            if (k == 0) exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            else        exp_q.push_back(mk(2'b01, 1'b0, 1'b1));
            @(negedge clk);
            got = {drive_en, sel, busy};
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("FAIL long_hold cyc%0d: got %b expected %b", k, got, e);
            else pass_cnt++;
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_drive();
        logic [3:0] e, got;
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) req = 2'b10;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                req = 2'b11;
            end
            if (k == 0)      exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            else if (k <= 3) exp_q.push_back(mk(2'b10, 1'b1, 1'b1));
            else if (k == 4) exp_q.push_back(mk(2'b00, 1'b0, 1'b0));
            else             exp_q.push_back(mk(2'b01, 1'b0, 1'b1));
            @(negedge clk);
            got = {drive_en, sel, busy};
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("FAIL reset_mid_drive cyc%0d: got %b expected %b", k, got, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev_de;
        logic [N-1:0] req_seen;
        int           gap;
        bit           driven_before;
        int           wait_cnt[N];
        do_reset();
        prev_de       = '0;
        req_seen      = '0;
        gap           = 0;
        driven_before = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            req_seen = req;
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            @(negedge clk);
            total_cnt++;
            if ($countones(drive_en) > 1)
                $display("FAIL onehot cyc%0d: got %b expected at most one bit", k, drive_en);
            else pass_cnt++;
            if (drive_en != '0) begin
                total_cnt++;
                if (drive_en !== (2'b01 << sel))
                    $display("FAIL sel_match cyc%0d: got sel %0d expected enable %b", k, sel, drive_en);
                else pass_cnt++;
            end
            if (drive_en != '0 && drive_en != prev_de) begin
                if (driven_before) begin
                    total_cnt++;
                    if (prev_de != '0 || gap < DEAD)
                        $display("FAIL dead_gap cyc%0d: got %0d idle cycles expected >= %0d", k,
                                 (prev_de != '0) ? 0 : gap, DEAD);
                    else pass_cnt++;
                end
                driven_before = 1'b1;
            end
            gap = (drive_en == '0) ? gap + 1 : 0;
            prev_de = drive_en;
            for (int i = 0; i < N; i++) begin
                if (req_seen[i] && !drive_en[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                total_cnt++;
                if (wait_cnt[i] > BOUND)
                    $display("FAIL wait_bound req%0d cyc%0d: got %0d expected <= %0d", i, k, wait_cnt[i], BOUND);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_hold_no_competitor();
        test_reset_mid_drive();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
